uart_tx_packetizer: RTL and testbench
=====================================

UART_TX_PACKETIZER -- requirements
Module: uart_tx_packetizer

Interface
REQ-001 Parameter WORDS_PER_PKT, default 4, meaning: payload words per full packet (1..15).
REQ-002 Parameter FIFO_DEPTH, default 8, meaning: word buffer depth (power of 2, at least WORDS_PER_PKT).
REQ-003 Port clk  in  1  meaning: the single clock; all logic rises on posedge clk.
REQ-004 Port rst  in  1  meaning: synchronous active-high reset.
REQ-005 Port word_in  in  16  meaning: payload word from the NN result path.
REQ-006 Port word_valid  in  1  meaning: word_in is valid.
REQ-007 Port word_ready  out  1  meaning: high when the FIFO is not full; a word is accepted when word_valid and word_ready are both high.
REQ-008 Port flush  in  1  meaning: single-cycle pulse requesting that a partial packet be sent.
REQ-009 Port tx_start  out  1  meaning: single-cycle start pulse to the UART transmitter.
REQ-010 Port tx_data  out  8  meaning: byte for the UART transmitter; held stable from the tx_start pulse until the byte completes.
REQ-011 Port tx_busy  in  1  meaning: busy flag from the UART transmitter.
REQ-012 Port pkt_active  out  1  meaning: high from packet start until the last byte completes.

Function
REQ-013 Frame format SHALL be: 0xA5, then LEN (count of words), then LEN words sent MSB byte first, then optional CHK.
REQ-014 A packet SHALL start from IDLE when FIFO count >= WORDS_PER_PKT, with LEN=WORDS_PER_PKT.
REQ-015 A packet SHALL also start on a pending flush with count>0, with LEN=count captured at start; a flush with count=0 SHALL be dropped.
REQ-016 A flush arriving while pkt_active is high SHALL be latched as pending and serviced after the current packet.
REQ-017 Main FSM: IDLE -> HDR -> LEN -> PAY_HI -> PAY_LO -> (PAY_HI while words remain) -> CHK -> IDLE.
REQ-018 Each byte SHALL use the handshake ISSUE (tx_start=1 for one cycle) -> WAIT_ACK (wait for tx_busy=1) -> WAIT_DONE (wait for tx_busy=0), then advance.
REQ-019 tx_start SHALL never be asserted while tx_busy=1; tx_data SHALL be unchanged from the ISSUE cycle through the WAIT_DONE exit.
REQ-020 The FIFO word SHALL be popped on the PAY_LO WAIT_DONE exit; the word SHALL be read (peeked) during PAY_HI and PAY_LO.
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged; a push when full SHALL be impossible because word_ready=0.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be $clog2(FIFO_DEPTH)+1.
REQ-023 Words pushed during a packet SHALL NOT alter its LEN.

Reset
REQ-024 On rst: FSM=IDLE, FIFO empty, flush-pending=0, tx_start=0, tx_data=0, pkt_active=0, word_ready=1 from the first cycle after reset.
REQ-025 rst asserted mid-packet SHALL abort the frame immediately; no further tx_start SHALL occur, and buffered words SHALL be discarded.

Configuration
REQ-026 Macro UART_PKT_CHECKSUM_EN defined: CHK byte = XOR of LEN and all payload bytes, sent after the last payload byte.
REQ-027 Macro UART_PKT_CHECKSUM_EN undefined: no CHK state; the FSM SHALL go from the last PAY_LO directly to IDLE, and the checksum register SHALL not exist.

Structure
REQ-028 Shared package uart_pkg SHALL hold: the FSM state enum, the byte-handshake sub-state enum, and the constant PKT_SYNC=8'hA5.
REQ-029 The FIFO SHALL be the sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-030 Push 0x1234, 0x5678, 0x9ABC, 0xDEF0 -> bytes A5 04 12 34 56 78 9A BC DE F0, then CHK=0x04 with checksum enabled.
REQ-031 Push 0x00FF, then flush -> bytes A5 01 00 FF, plus CHK=0xFE when enabled; pkt_active falls after the last byte completes.
REQ-032 Flush with an empty FIFO -> no tx_start; flush during an active packet with 2 words queued -> a second packet with LEN=02 follows.
REQ-033 With the UART model holding busy for 100 cycles per byte, push 8 words back-to-back -> word_ready=0 once the FIFO is full, no words lost, two packets sent in order.
REQ-034 Assert rst during PAY_LO of packet 1 -> tx_start stays 0 afterwards, word_ready=1, and the next 4 pushed words produce a clean packet.
REQ-035 Bench assertion: tx_start never high while tx_busy=1, and tx_data stable during each byte, across all scenarios.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART packetizer: packet FSM states, per-byte handshake
// sub-states and the frame sync byte.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_LEN    = 3'd2,
        ST_PAY_HI = 3'd3,
        ST_PAY_LO = 3'd4,
        ST_CHK    = 3'd5
    } pkt_state_t;

    typedef enum logic [1:0] {
        HS_ISSUE     = 2'd0,
        HS_WAIT_ACK  = 2'd1,
        HS_WAIT_DONE = 2'd2
    } hs_state_t;

    localparam logic [7:0] PKT_SYNC = 8'hA5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with a show-ahead read port (rdata is the head word).
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_packetizer.sv
// Buffers 16-bit result words and frames them as A5, LEN, payload (MSB first)
// bytes for a UART transmitter. Define UART_PKT_CHECKSUM_EN to append an XOR CHK byte.
module uart_tx_packetizer
    import uart_pkg::*;
#(
    parameter int WORDS_PER_PKT = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        flush,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        pkt_active
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   fifo_word;
    logic          fifo_pop;

    pkt_state_t    state;
    pkt_state_t    next_state;
    hs_state_t     hs;
    logic [3:0]    len_q;
    logic [3:0]    words_left;
    logic          flush_pend;
    logic          flush_req;
    logic          byte_done;
    logic          full_ready;
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0]    chk_q;
`endif

    sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (word_valid && word_ready),
        .pop   (fifo_pop),
        .wdata (word_in),
        .rdata (fifo_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign word_ready = !fifo_full;
    assign pkt_active = (state != ST_IDLE);
    assign flush_req  = flush || flush_pend;
    assign full_ready = (fifo_count >= CW'(WORDS_PER_PKT));
    assign byte_done  = (state != ST_IDLE) && (hs == HS_WAIT_DONE) && !tx_busy;
    assign fifo_pop   = byte_done && (state == ST_PAY_LO);
    // Gating on tx_busy keeps a stale busy from a reset-aborted byte from overlapping.
    assign tx_start   = (state != ST_IDLE) && (hs == HS_ISSUE) && !tx_busy;

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_HDR:    next_state = ST_LEN;
            ST_LEN:    next_state = ST_PAY_HI;
            ST_PAY_HI: next_state = ST_PAY_LO;
`ifdef UART_PKT_CHECKSUM_EN
            ST_PAY_LO: next_state = (words_left == 4'd1) ? ST_CHK : ST_PAY_HI;
`else
            ST_PAY_LO: next_state = (words_left == 4'd1) ? ST_IDLE : ST_PAY_HI;
`endif
            default:   next_state = ST_IDLE;
        endcase
    end

    // Byte content depends only on registered state and the un-popped FIFO head,
    // so it holds for the whole ISSUE..WAIT_DONE window.
    always_comb begin
        tx_data = 8'h00;
        case (state)
            ST_HDR:    tx_data = PKT_SYNC;
            ST_LEN:    tx_data = {4'h0, len_q};
            ST_PAY_HI: tx_data = fifo_word[15:8];
            ST_PAY_LO: tx_data = fifo_word[7:0];
`ifdef UART_PKT_CHECKSUM_EN
            ST_CHK:    tx_data = chk_q;
`endif
            default:   tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hs         <= HS_ISSUE;
            len_q      <= '0;
            words_left <= '0;
            flush_pend <= 1'b0;
        end else if (state == ST_IDLE) begin
            hs <= HS_ISSUE;
            if (full_ready) begin
                state      <= ST_HDR;
                len_q      <= 4'(WORDS_PER_PKT);
                flush_pend <= flush_req;
            end else if (flush_req && !fifo_empty) begin
                state      <= ST_HDR;
                len_q      <= 4'(fifo_count);
                flush_pend <= 1'b0;
            end else begin
                flush_pend <= 1'b0;
            end
        end else begin
            if (flush) flush_pend <= 1'b1;
            case (hs)
                HS_ISSUE:     if (!tx_busy) hs <= HS_WAIT_ACK;
                HS_WAIT_ACK:  if (tx_busy) hs <= HS_WAIT_DONE;
                HS_WAIT_DONE: if (!tx_busy) begin
                    hs    <= HS_ISSUE;
                    state <= next_state;
                end
                default:      hs <= HS_ISSUE;
            endcase
            if (byte_done && state == ST_LEN) words_left <= len_q;
            if (fifo_pop) words_left <= words_left - 4'd1;
        end
    end

`ifdef UART_PKT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE) begin
            chk_q <= 8'h00;
        end else if (byte_done && (state == ST_LEN || state == ST_PAY_HI || state == ST_PAY_LO)) begin
            chk_q <= chk_q ^ tx_data;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Bench for uart_tx_packetizer: UART model with random or long busy times, byte
// scoreboard fed from a word-level packet model, handshake/stability assertions.
module tb_uart_tx_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        flush = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        pkt_active;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] words_q[$];
    int          byte_cnt = 0;
    int          busy_cnt = 0;
    bit          long_busy = 1'b0;
    bit          byte_open = 1'b0;
    logic [7:0]  held_byte = '0;

    always #5 clk = ~clk;

    uart_tx_packetizer #(.WORDS_PER_PKT(4), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .flush      (flush),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .pkt_active (pkt_active)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: sync, length, words MSB first, optional XOR checksum.
    function automatic void emit(input int n);
        logic [7:0]  chk;
        logic [15:0] w;
        chk = 8'(n);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = words_q.pop_front();
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
            chk = chk ^ w[15:8] ^ w[7:0];
        end
`ifdef UART_PKT_CHECKSUM_EN
        exp_q.push_back(chk);
`endif
    endfunction

    // UART transmitter model and byte scoreboard.
    always @(posedge clk) begin
        if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) tx_busy <= 1'b0;
        end else if (tx_start) begin
            tx_busy   <= 1'b1;
            busy_cnt  <= long_busy ? 100 : int'($urandom_range(1, 4));
            byte_cnt  = byte_cnt + 1;
            held_byte = tx_data;
            byte_open = 1'b1;
            check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (tx_start) check("start_while_busy", 32'(tx_busy), 32'd0);
        if (byte_open && tx_busy) check("tx_data_stable", 32'(tx_data), 32'(held_byte));
        if (!tx_busy) byte_open = 1'b0;
    end

    task automatic push_word(input logic [15:0] w);
        int n = 0;
        @(negedge clk);
        while (!word_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(word_ready), 32'd1);
        word_in    = w;
        word_valid = 1'b1;
        @(posedge clk);
        #1 word_valid = 1'b0;
        words_q.push_back(w);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Waits for all expected bytes to finish, then checks pkt_active drops one cycle later.
    task automatic wait_done(input string tag, input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tx_busy && busy_cnt == 0) done = 1'b1;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_active_last"}, 32'(pkt_active), 32'd1);
        @(negedge clk);
        check({tag, "_active_fall"}, 32'(pkt_active), 32'd0);
    endtask

    initial begin
        int base;
        int k;
        bit hit;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_word_ready", 32'(word_ready), 32'd1);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_pkt_active", 32'(pkt_active), 32'd0);

        // Full packet of four known words.
        push_word(16'h1234);
        push_word(16'h5678);
        push_word(16'h9ABC);
        push_word(16'hDEF0);
        emit(4);
        wait_done("full4", 500);

        // Single word flushed as a partial packet.
        push_word(16'h00FF);
        emit(1);
        pulse_flush();
        wait_done("flush1", 300);

        // Flush with nothing buffered sends nothing.
        base = byte_cnt;
        pulse_flush();
        repeat (40) @(negedge clk);
        check("empty_flush_no_start", 32'(byte_cnt), 32'(base));
        check("empty_flush_idle", 32'(pkt_active), 32'd0);

        // Flush latched during an active packet with two words queued.
        for (int i = 0; i < 4; i++) push_word(16'($urandom_range(0, 16'hFFFF)));
        emit(4);
        push_word(16'($urandom_range(0, 16'hFFFF)));
        push_word(16'($urandom_range(0, 16'hFFFF)));
        check("flush_during_active", 32'(pkt_active), 32'd1);
        pulse_flush();
        emit(2);
        wait_done("pend_flush", 800);

        // Random-length partial packets.
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) push_word(16'($urandom_range(0, 16'hFFFF)));
            emit(k);
            pulse_flush();
            wait_done("rand_flush", 400);
        end

        // Slow UART: eight back-to-back words fill the FIFO, two packets follow.
        long_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_word(16'($urandom_range(0, 16'hFFFF)));
            if (i == 3 || i == 7) emit(4);
        end
        @(negedge clk);
        check("full_word_ready_low", 32'(word_ready), 32'd0);
        wait_done("slow_two_pkts", 5000);
        long_busy = 1'b0;

        // Reset during PAY_LO of the first word aborts the frame and drops the buffer.
        for (int i = 0; i < 4; i++) push_word(16'($urandom_range(0, 16'hFFFF)));
        emit(4);
        base = byte_cnt;
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            if (byte_cnt >= base + 4) hit = 1'b1;
            else @(negedge clk);
        end
        check("reach_pay_lo", 32'(hit), 32'd1);
        byte_open = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        words_q.delete();
        base = byte_cnt;
        check("abort_word_ready", 32'(word_ready), 32'd1);
        check("abort_pkt_active", 32'(pkt_active), 32'd0);
        repeat (40) @(negedge clk);
        check("abort_no_start", 32'(byte_cnt), 32'(base));
        for (int i = 0; i < 4; i++) push_word(16'($urandom_range(0, 16'hFFFF)));
        emit(4);
        wait_done("after_abort", 500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
